// File: rtl/sound_decim.sv
// Stereo audio decimator: box-filter average over each output sample period,
// serial restoring divide, volume shift, and a small output FIFO.
module sound_decim #(
  parameter int OUT_RATE   = 48000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [27:0]        clock_rate,
  input  logic signed [15:0] in_l,
  input  logic signed [15:0] in_r,
  input  logic [3:0]         volume,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_l,
  output logic signed [15:0] out_r,
  output logic               overflow
);
  localparam int AW = 33;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_PUSH} state_t;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } sample_t;

  logic [27:0]        clk_rate_q, clk_rate_d;
  logic [AW-1:0]      acc_q, acc_d, acc_sum;
  logic               tick, capture, wr, push, pop, full;
  logic signed [31:0] sum_l_q, sum_l_d, sum_r_q, sum_r_d;
  logic [15:0]        cnt_q, cnt_d;
  state_t             state_q, state_d;
  logic [4:0]         step_q, step_d;
  logic [31:0]        dvd_l_q, dvd_l_d, dvd_r_q, dvd_r_d;
  logic [16:0]        rem_l_q, rem_l_d, rem_r_q, rem_r_d;
  logic [15:0]        dsr_q, dsr_d;
  logic               neg_l_q, neg_l_d, neg_r_q, neg_r_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      fill_q, fill_d;
  logic               ovf_q, ovf_d;
  sample_t            res;
  sample_t            mem [FIFO_DEPTH];

  function automatic logic [31:0] magnitude(input logic signed [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // One restoring step: returns {remainder, dividend shifted with quotient bit}.
  function automatic logic [48:0] div_step(input logic [16:0] rem,
                                           input logic [31:0] dvd,
                                           input logic [15:0] dsr);
    logic [16:0] r;
    r = {rem[15:0], dvd[31]};
    if (r >= {1'b0, dsr}) return {r - {1'b0, dsr}, dvd[30:0], 1'b1};
    return {r, dvd[30:0], 1'b0};
  endfunction

  function automatic logic signed [15:0] div_result(input logic [31:0] q,
                                                    input logic        neg,
                                                    input logic        zero,
                                                    input logic [3:0]  vol);
    logic signed [15:0] s;
    if (zero)                s = '0;
    else if (neg)            s = (q > 32'd32768) ? 16'sh8000 : 16'(~q + 32'd1);
    else                     s = (q > 32'd32767) ? 16'sh7FFF : 16'(q);
    if (vol == 4'd15) return '0;
    return s >>> vol;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    acc_sum = acc_q + AW'(OUT_RATE);
    acc_d   = acc_q;
    tick    = 1'b0;
    if (clk_rate_q != '0) begin
      if (acc_sum >= AW'(clk_rate_q)) begin
        acc_d = acc_sum - AW'(clk_rate_q);
        tick  = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_comb begin
    clk_rate_d = clock_rate;
    sum_l_d    = sum_l_q;
    sum_r_d    = sum_r_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    step_d     = step_q;
    dvd_l_d    = dvd_l_q;
    dvd_r_d    = dvd_r_q;
    rem_l_d    = rem_l_q;
    rem_r_d    = rem_r_q;
    dsr_d      = dsr_q;
    neg_l_d    = neg_l_q;
    neg_r_d    = neg_r_q;
    wr         = 1'b0;
    capture    = tick && (state_q == S_IDLE);

    if (capture) begin
      sum_l_d = 32'(in_l);
      sum_r_d = 32'(in_r);
      cnt_d   = 16'd1;
    end else if (cnt_q != 16'hFFFF) begin
      sum_l_d = sum_l_q + 32'(in_l);
      sum_r_d = sum_r_q + 32'(in_r);
      cnt_d   = cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: if (capture) begin
        state_d = S_DIV;
        step_d  = '0;
        dvd_l_d = magnitude(sum_l_q);
        dvd_r_d = magnitude(sum_r_q);
        neg_l_d = sum_l_q[31];
        neg_r_d = sum_r_q[31];
        rem_l_d = '0;
        rem_r_d = '0;
        dsr_d   = cnt_q;
      end
      S_DIV: begin
        {rem_l_d, dvd_l_d} = div_step(rem_l_q, dvd_l_q, dsr_q);
        {rem_r_d, dvd_r_d} = div_step(rem_r_q, dvd_r_q, dsr_q);
        step_d = step_q + 5'd1;
        if (step_q == 5'd31) state_d = S_PUSH;
      end
      S_PUSH: begin
        wr      = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res.l = div_result(dvd_l_q, neg_l_q, dsr_q == '0, volume);
    res.r = div_result(dvd_r_q, neg_r_q, dsr_q == '0, volume);
    full  = (fill_q == CW'(FIFO_DEPTH));
    pop   = out_valid && out_ready;
    push  = wr && (!full || pop);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fill_d   = fill_q;
    if (push && !pop)      fill_d = fill_q + 1'b1;
    else if (pop && !push) fill_d = fill_q - 1'b1;
    ovf_d = ovf_q || (tick && state_q != S_IDLE) || (wr && full && !pop);
  end

  assign out_valid = (fill_q != '0);
  assign out_l     = out_valid ? mem[rd_ptr_q].l : '0;
  assign out_r     = out_valid ? mem[rd_ptr_q].r : '0;
  assign overflow  = ovf_q;

  // NOTE: FIFO storage has no reset; empty-state outputs are masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= res;
  end

  // NOTE: all state updates are non-blocking so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_rate_q <= '0;
      acc_q      <= '0;
      sum_l_q    <= '0;
      sum_r_q    <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      step_q     <= '0;
      dvd_l_q    <= '0;
      dvd_r_q    <= '0;
      rem_l_q    <= '0;
      rem_r_q    <= '0;
      dsr_q      <= '0;
      neg_l_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      clk_rate_q <= clk_rate_d;
      acc_q      <= acc_d;
      sum_l_q    <= sum_l_d;
      sum_r_q    <= sum_r_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      step_q     <= step_d;
      dvd_l_q    <= dvd_l_d;
      dvd_r_q    <= dvd_r_d;
      rem_l_q    <= rem_l_d;
      rem_r_q    <= rem_r_d;
      dsr_q      <= dsr_d;
      neg_l_q    <= neg_l_d;
      neg_r_q    <= neg_r_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sound_decim.sv
// Scoreboard bench for sound_decim: a behavioural reference queues expected
// samples at write time and compares them as the consumer pops them.
module tb_sound_decim;
  localparam int OUT_RATE = 48000;
  localparam int DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] clock_rate = 28'd4800000;
  logic [15:0] in_l = 16'hFC18;
  logic [15:0] in_r = 16'h01F4;
  logic [3:0]  volume = 4'd0;
  logic        out_ready = 1'b1;
  logic        out_valid, overflow;
  logic [15:0] out_l, out_r;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  logic [15:0] last_l = '0, last_r = '0;
  bit alt_mode = 1'b0;

  // Reference model state (post-edge view)
  logic [31:0] exp_q [$];
  longint m_acc = 0, m_rate = 0;
  int     m_sum_l = 0, m_sum_r = 0, m_cnt = 0;
  bit     m_ovf = 1'b0, pend = 1'b0;
  int     pend_due = 0, pend_sl = 0, pend_sr = 0, pend_cnt = 0;
  int     m_busy_until = 0, m_last_tick = -1, cyc = 0;

  sound_decim #(.OUT_RATE(OUT_RATE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clock_rate(clock_rate), .in_l(in_l), .in_r(in_r),
    .volume(volume), .out_valid(out_valid), .out_ready(out_ready),
    .out_l(out_l), .out_r(out_r), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_sample(input int sum, input int cnt, input logic [3:0] vol);
    longint q;
    if (cnt == 0) q = 0;
    else q = longint'(sum) / longint'(cnt);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    if (vol == 4'd15) q = 0;
    else q = q >>> vol;
    return q[15:0];
  endfunction

  // Inputs change at posedge+2; the model compares at negedge and then
  // predicts the effect of the coming posedge.
  always @(negedge clk) begin
    logic [31:0] e;
    longint a;
    bit t;
    if (rst) begin
      check("rst_out", {out_valid, overflow, out_l, out_r}, 64'd0);
      exp_q.delete();
      m_acc = 0; m_rate = 0; m_sum_l = 0; m_sum_r = 0; m_cnt = 0;
      m_ovf = 1'b0; pend = 1'b0; m_busy_until = 0;
    end else begin
      check("valid", out_valid, exp_q.size() != 0);
      check("ovf", overflow, m_ovf);
      if (exp_q.size() == 0) check("empty_zero", {out_l, out_r}, 64'd0);
      if (exp_q.size() != 0 && out_ready) begin
        e = exp_q.pop_front();
        check("out_l", out_l, e[31:16]);
        check("out_r", out_r, e[15:0]);
        last_l = out_l; last_r = out_r;
        n_pops++;
      end
      if (pend && cyc == pend_due) begin
        pend = 1'b0;
        if (exp_q.size() == DEPTH) m_ovf = 1'b1;
        else exp_q.push_back({ref_sample(pend_sl, pend_cnt, volume),
                              ref_sample(pend_sr, pend_cnt, volume)});
      end
      t = 1'b0;
      if (m_rate != 0) begin
        a = m_acc + OUT_RATE;
        if (a >= m_rate) begin m_acc = a - m_rate; t = 1'b1; end
        else m_acc = a;
      end
      if (t) m_last_tick = cyc;
      if (t && cyc >= m_busy_until) begin
        pend = 1'b1; pend_due = cyc + 33; m_busy_until = cyc + 34;
        pend_sl = m_sum_l; pend_sr = m_sum_r; pend_cnt = m_cnt;
        m_sum_l = int'($signed(in_l)); m_sum_r = int'($signed(in_r)); m_cnt = 1;
      end else begin
        if (t) m_ovf = 1'b1;
        if (m_cnt != 65535) begin
          m_sum_l += int'($signed(in_l)); m_sum_r += int'($signed(in_r)); m_cnt++;
        end
      end
      m_rate = longint'(clock_rate);
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      if (alt_mode) in_l = (in_l == 16'h7FFF) ? 16'h8000 : 16'h7FFF;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    int snap, t0;
    step(3);
    rst = 1'b0;

    // Constant input, full volume, then attenuated, then muted
    step(350);
    check("avg_l", last_l, 16'hFC18);
    check("avg_r", last_r, 16'h01F4);
    volume = 4'd2;
    step(300);
    check("vol2_l", last_l, 16'hFF06);
    check("vol2_r", last_r, 16'h007D);
    volume = 4'd15;
    step(300);
    check("mute", {last_l, last_r}, 64'd0);
    check("ovf_vol", overflow, 1'b0);

    // Full-scale alternating left channel averages to zero
    volume = 4'd0;
    alt_mode = 1'b1;
    in_l = 16'h7FFF;
    step(300);
    check("alt_l", last_l, 16'h0000);
    check("alt_r", last_r, 16'h01F4);
    alt_mode = 1'b0;

    // Back-pressure: six writes into a four-entry FIFO
    out_ready = 1'b0;
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      in_l = 16'(-1000 + 150 * k);
      step(100);
    end
    step(50);
    check("bp_ovf", overflow, 1'b1);
    check("bp_full", out_valid, 1'b1);
    snap = n_pops;
    out_ready = 1'b1;
    step(6);
    check("bp_pops", n_pops - snap, 4);
    check("bp_drained", out_valid, 1'b0);

    // Fast tick rates: 40 clocks per tick keeps up, 20 does not
    in_l = 16'hFC18;
    clock_rate = 28'd1920000;
    pulse_reset();
    step(400);
    check("fast_ovf", overflow, 1'b0);
    clock_rate = 28'd960000;
    step(200);
    check("faster_ovf", overflow, 1'b1);

    // Reset during a divide drops the pending result
    clock_rate = 28'd4800000;
    pulse_reset();
    t0 = m_last_tick;
    for (int i = 0; i < 300 && m_last_tick == t0; i++) step(1);
    check("tick_seen", m_last_tick != t0, 1'b1);
    step(10);
    pulse_reset();
    snap = n_pops;
    step(120);
    check("abort_nopop", n_pops - snap, 0);
    check("abort_out", {out_valid, overflow, out_l, out_r}, 64'd0);
    step(60);
    check("post_abort_pop", n_pops - snap, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
